bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side initiator for one port of the true dual-port block RAM. On start, it
//  issues a burst of reads from base_addr for length words and tracks the RAM's
//  fixed read latency. Returned words go into a small credit-controlled FIFO and
//  leave as a valid/ready stream with a last flag. It feeds downstream compute from
//  frame/weight RAM while the other RAM port is written independently.
// PARAMETERS
//  DATA_W        32        RAM word width (matches RAM_WIDTH)
//  RAM_DEPTH     32'h5_0000 number of RAM entries; address wrap point
//  ADDR_W        19        address width = clogb2(RAM_DEPTH-1)
//  LEN_W         20        burst length width (ADDR_W+1, allows full-RAM burst)
//  READ_LATENCY  2         en-to-dout cycles (2 = output register, 1 = no register)
//  FIFO_DEPTH    4         return buffer entries; must be >= READ_LATENCY+1
// PORTS
//  clk        in   1       clock; RAM port clock is the same clk
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_W  first word address, < RAM_DEPTH
//  length     in   LEN_W   number of words to read
//  abort      in   1       cancel the current burst
//  busy       out  1       high from the cycle after accepted start until return to IDLE
//  done       out  1       1-cycle pulse: burst completed or aborted
//  ram_en     out  1       RAM port enable (1 = issue read this cycle)
//  ram_we     out  1       RAM port write enable; constant 0
//  ram_addr   out  ADDR_W  RAM port address
//  ram_regce  out  1       RAM output-register enable; high whenever busy
//  ram_rst    out  1       RAM output-register reset; constant 0
//  ram_dout   in   DATA_W  RAM port read data
//  m_valid    out  1       stream word valid
//  m_data     out  DATA_W  stream word (FIFO head)
//  m_last     out  1       high with the final word of the burst
//  m_ready    in   1       downstream accept
// BEHAVIOUR
//  Reset: busy, done, ram_en, ram_regce, m_valid and m_last are 0. ram_addr and m_data are 0.
//    FIFO is empty, inflight is 0, and the state is IDLE.
//  FSM states: IDLE, ISSUE, DRAIN, FINISH.
//   IDLE   start=1 and length>0 -> ISSUE. Latch addr=base_addr and remaining=length.
//          start=1 and length=0 -> FINISH. No RAM access occurs.
//   ISSUE  ram_en=1 when credit = (fifo_count + inflight) < FIFO_DEPTH.
//          Each issue: addr advances, wrapping from RAM_DEPTH-1 to 0; remaining decrements.
//          When the last read is issued -> DRAIN.
//   DRAIN  no issue. Wait until inflight==0 and the last word has been accepted -> FINISH.
//   FINISH done=1 for exactly 1 cycle, busy=0 -> IDLE. A new start is accepted in the next IDLE cycle.
//  Credit accounting is conservative: a pop in the same cycle does not free credit for an
//    issue in that cycle. With FIFO_DEPTH >= READ_LATENCY+1 and m_ready held high,
//    throughput is 1 word/clk.
//  Latency: read issued at cycle t (ram_en=1). ram_dout is captured into the FIFO at
//    t+READ_LATENCY, using a READ_LATENCY-deep valid shift register. m_valid rises at
//    t+READ_LATENCY+1, so first-word latency from start is READ_LATENCY+2.
//  Stream rules: m_data, m_valid and m_last hold stable while m_valid && !m_ready.
//    A beat transfers on m_valid && m_ready.
//  m_last: a word-returned counter tags the length-th captured word. Exactly one beat per burst has m_last=1.
//  FIFO: simultaneous push and pop when full or empty is legal. Overflow cannot occur by
//    construction; the bench asserts this.
//  abort (any non-IDLE state): issue stops at once. In-flight returns are discarded.
//    The FIFO is flushed. m_valid=0 the next cycle. -> FINISH (done pulse). No m_last is emitted.
//    abort in IDLE is ignored. abort has priority over start.
//  start while not IDLE: ignored; base_addr and length are sampled only in IDLE.
//  ram_we and ram_rst are never asserted. The RAM holds its last read value while ram_en=0.
//  Async reset mid-burst returns to the reset state immediately. Outstanding RAM data is ignored.
// TESTING
//  1 RAM preloaded mem[i]=i. base=0x10, length=8, m_ready=1 -> data 0x10..0x17, 1/clk.
//    m_last on 0x17. First m_valid 4 clks after start. done 1 clk after the last beat.
//  2 Wrap: base=0x4FFFE, length=4 -> ram_addr sequence 0x4FFFE, 0x4FFFF, 0x0, 0x1.
//    Data follows the same order.
//  3 Backpressure: length=16, m_ready toggles 1,0,0,1... -> no loss or duplication.
//    inflight+count never exceeds 4. m_data stable while stalled.
//  4 length=0 -> no ram_en. done pulses 1 clk after start. No m_valid.
//  5 abort after 3 accepted beats of length=10 -> ram_en drops the same clk. m_valid=0 the next clk.
//    done pulses once, no m_last. A new burst (base=0, length=2) then returns 0, 1.
//  6 rst_n low mid-burst for 1 clk -> all outputs 0 asynchronously. A subsequent burst is correct.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Burst read initiator for one block-RAM port.
// Tracks fixed read latency and streams returns through a credit-limited FIFO.
module bram_stream_reader #(
  parameter int DATA_W       = 32,
  parameter int RAM_DEPTH    = 32'h5_0000,
  parameter int ADDR_W       = 19,
  parameter int LEN_W        = 20,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(READ_LATENCY + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]              state;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W-1:0]       addr_nx;
  logic [LEN_W-1:0]        remaining;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        ret_cnt;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [IF_W-1:0]         inflight;
  logic [31:0]             occ;
  logic                    credit;
  logic                    push;
  logic                    push_last;
  logic                    pop;
  logic                    flush;

  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              mem_l [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight = inflight + IF_W'(vld_sr[i]);
  end

  // Pops do not free credit in the same cycle
  assign occ    = 32'(fifo_cnt) + 32'(inflight);
  assign credit = occ < 32'(FIFO_DEPTH);

  assign flush     = abort && (state == S_ISSUE || state == S_DRAIN);
  assign ram_en    = (state == S_ISSUE) && credit && !abort;
  assign push      = vld_sr[READ_LATENCY-1] && !flush;
  assign push_last = (ret_cnt == len_q - LEN_W'(1));
  assign pop       = m_valid && m_ready;

  assign addr_nx = (addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr + 1'b1;

  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign done      = (state == S_FINISH);
  assign ram_regce = busy;
  assign ram_we    = 1'b0;
  assign ram_rst   = 1'b0;
  assign ram_addr  = addr;

  assign m_valid = (fifo_cnt != '0);
  assign m_data  = m_valid ? mem_d[rd_ptr] : '0;
  assign m_last  = m_valid && mem_l[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= ram_dout;
      mem_l[wr_ptr] <= push_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ret_cnt  <= '0;
    end else if (flush) begin
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      vld_sr[0] <= ram_en;
      for (int i = 1; i < READ_LATENCY; i++)
        vld_sr[i] <= vld_sr[i-1];
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop)
        fifo_cnt <= fifo_cnt - 1'b1;
      if (state == S_IDLE)
        ret_cnt <= '0;
      else if (push)
        ret_cnt <= ret_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= length;
            len_q     <= length;
            state     <= (length != '0) ? S_ISSUE : S_FINISH;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_FINISH;
          end else if (ram_en) begin
            addr      <= addr_nx;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort)
            state <= S_FINISH;
          else if (pop && m_last && inflight == '0)
            state <= S_FINISH;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader.
// RAM model returns mem[i]=i with a two-cycle registered read.
module tb_bram_stream_reader;

  localparam int RD = 32'h5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [18:0] base_addr;
  logic [19:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic        ram_en;
  logic        ram_we;
  logic [18:0] ram_addr;
  logic        ram_regce;
  logic        ram_rst;
  logic [31:0] ram_dout = '0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  bram_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mem[i] = i, read registered then output-registered
  logic [18:0] lat = '0;
  always @(posedge clk) begin
    if (ram_en) lat <= ram_addr;
    if (ram_regce) ram_dout <= {13'b0, lat};
  end

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [18:0] aq[$];
  exp_t        e;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int beats, vcnt, en_cnt, done_cnt, last_cnt;
  int first_v, done_cyc, last_cyc, st_cyc;
  int issued, accepted;
  bit rdy_mode;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_v", 64'(m_valid), 1);
        check("hold_d", 64'(m_data), 64'(prev_data));
        check("hold_l", 64'(m_last), 64'(prev_last));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (ram_en) begin
        en_cnt++;
        issued++;
        check("occ", 64'((issued - accepted) <= 4), 1);
        if (aq.size() > 0) check("addr", 64'(ram_addr), 64'(aq.pop_front()));
        else check("addr_extra", 1, 0);
      end
      if (m_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
      end
      if (m_valid && m_ready) begin
        beats++;
        accepted++;
        if (m_last) begin
          last_cnt++;
          last_cyc = cyc;
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("data", 64'(m_data), 64'(e.d));
          check("last", 64'(m_last), 64'(e.l));
        end else begin
          check("beat_extra", 1, 0);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_burst(input int base, input int len);
    exp_t x;
    int   a;
    @(posedge clk);
    #1;
    base_addr = 19'(base);
    length    = 20'(len);
    start     = 1'b1;
    for (int k = 0; k < len; k++) begin
      a = (base + k) % RD;
      aq.push_back(19'(a));
      x.d = 32'(a);
      x.l = (k == len - 1);
      sb.push_back(x);
    end
    beats = 0; vcnt = 0; en_cnt = 0; done_cnt = 0; last_cnt = 0;
    first_v = -1; done_cyc = -1; last_cyc = -1;
    issued = 0; accepted = 0;
    st_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input int ab_at);
    int n = 0;
    bit ab_done = 1'b0;
    while (done_cnt == 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy_mode) m_ready = (cyc % 3 == 0);
      if (ab_at > 0 && !ab_done && beats >= ab_at) begin
        abort = 1'b1;
        #1;
        check("abort_en", 64'(ram_en), 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_mv", 64'(m_valid), 0);
        ab_done = 1'b1;
      end
    end
    if (done_cnt == 0) check("timeout", 0, 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    base_addr = '0; length = '0; rdy_mode = 1'b0;
    beats = 0; done_cnt = 0;
    #1;
    check("rst_outs", 64'({busy, done, ram_en, ram_regce, m_valid,
                           m_last, ram_we, ram_rst}), 0);
    check("rst_addr", 64'(ram_addr), 0);
    check("rst_data", 64'(m_data), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    start_burst(32'h10, 8);
    wait_done(100, 0);
    check("t1_first", 64'(first_v - st_cyc), 4);
    check("t1_rate", 64'(last_cyc - first_v), 7);
    check("t1_done", 64'(done_cyc - last_cyc), 1);
    check("t1_beats", 64'(beats), 8);
    check("t1_lastn", 64'(last_cnt), 1);
    check("t1_en", 64'(en_cnt), 8);
    settle();
    check("t1_done1", 64'(done_cnt), 1);
    check("t1_sb", 64'(sb.size()), 0);

    start_burst(32'h4FFFE, 4);
    wait_done(100, 0);
    check("t2_beats", 64'(beats), 4);
    check("t2_aq", 64'(aq.size()), 0);
    check("t2_sb", 64'(sb.size()), 0);

    rdy_mode = 1'b1;
    start_burst(32'h100, 16);
    wait_done(300, 0);
    rdy_mode = 1'b0;
    m_ready  = 1'b1;
    check("t3_beats", 64'(beats), 16);
    check("t3_lastn", 64'(last_cnt), 1);
    check("t3_sb", 64'(sb.size()), 0);

    start_burst(0, 0);
    wait_done(20, 0);
    check("t4_done", 64'(done_cyc - st_cyc), 1);
    check("t4_en", 64'(en_cnt), 0);
    check("t4_valid", 64'(vcnt), 0);

    start_burst(32'h40, 10);
    wait_done(100, 3);
    check("t5_lastn", 64'(last_cnt), 0);
    settle();
    check("t5_done1", 64'(done_cnt), 1);
    check("t5_valid", 64'(m_valid), 0);
    sb.delete();
    aq.delete();
    start_burst(0, 2);
    wait_done(100, 0);
    check("t5_beats", 64'(beats), 2);
    check("t5_lastn2", 64'(last_cnt), 1);
    check("t5_sb", 64'(sb.size()), 0);

    start_burst(32'h200, 8);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_outs", 64'({busy, done, ram_en, ram_regce, m_valid, m_last}), 0);
    check("t6_addr", 64'(ram_addr), 0);
    check("t6_data", 64'(m_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    aq.delete();
    start_burst(32'h300, 5);
    wait_done(100, 0);
    check("t6_beats", 64'(beats), 5);
    check("t6_lastn", 64'(last_cnt), 1);
    check("t6_sb", 64'(sb.size()), 0);

    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
